// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: hazard-control bundle; master = datapath, slave = pipe_hazard_ctrl.
//   sources  : rs1_d rs2_d rs1_e rs2_e rd_e rd_m rd_w load_e regwrite_m regwrite_w pc_src_e mem_req_m mem_ready
//   controls : en_f en_d en_e en_m en_w clr_d clr_e clr_w fwd_a_e fwd_b_e mem_timeout
//   HAZARD_PERF_CNT_EN adds stall_cnt / flush_cnt
interface pipe_hazard_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic load_e, regwrite_m, regwrite_w, pc_src_e, mem_req_m, mem_ready;
  logic en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_w;
  logic [1:0] fwd_a_e, fwd_b_e;
  logic mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif
  modport master(
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output load_e, regwrite_m, regwrite_w, pc_src_e, mem_req_m, mem_ready,
    input en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_w, fwd_a_e, fwd_b_e, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , input stall_cnt, flush_cnt
`endif
  );
  modport slave(
    input rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input load_e, regwrite_m, regwrite_w, pc_src_e, mem_req_m, mem_ready,
    output en_f, en_d, en_e, en_m, en_w, clr_d, clr_e, clr_w, fwd_a_e, fwd_b_e, mem_timeout
`ifdef HAZARD_PERF_CNT_EN
    , output stall_cnt, flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline enables/clears, E-stage forwarding and memory-wait timeout FSM.
//   clk, reset (sync, active-high); hz = pipe_hazard_if.slave
//   HAZARD_PERF_CNT_EN adds saturating stall/flush counters
module pipe_hazard_ctrl #(
  parameter int REG_AW = 5,
  parameter int MAX_WAIT = 16
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input logic clk,
  input logic reset,
  pipe_hazard_if.slave hz
);
  localparam int CW = $clog2(MAX_WAIT);
  localparam logic [REG_AW-1:0] ZERO = '0;
  typedef enum logic [1:0] {IDLE, WAIT, TMO} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic lu, mstall;
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = state;
    cnt_nxt = cnt;
    case (state)
      IDLE: if (hz.mem_req_m && !hz.mem_ready) begin
        state_nxt = WAIT;
        cnt_nxt = CW'(1);
      end
      WAIT: if (hz.mem_ready) begin
        state_nxt = IDLE;
        cnt_nxt = '0;
      end else if (cnt == CW'(MAX_WAIT - 1)) state_nxt = TMO;
      else cnt_nxt = cnt + 1'b1;
      default: ;
    endcase
  end
  // mstall dominates; a branch resolving during a stall stays frozen in E until release
  always_comb begin
    hz.mem_timeout = state == TMO;
    lu = hz.load_e && hz.rd_e != ZERO && (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);
    mstall = hz.mem_req_m && !hz.mem_ready && !hz.mem_timeout;
    hz.en_f = !mstall && (hz.pc_src_e || !lu);
    hz.en_d = !mstall && (hz.pc_src_e || !lu);
    hz.en_e = !mstall;
    hz.en_m = !mstall;
    hz.en_w = 1'b1;
    hz.clr_d = !mstall && hz.pc_src_e;
    hz.clr_e = !mstall && (hz.pc_src_e || lu);
    hz.clr_w = mstall;
    hz.fwd_a_e = (hz.regwrite_m && hz.rd_m != ZERO && hz.rd_m == hz.rs1_e) ? 2'b10 :
                 (hz.regwrite_w && hz.rd_w != ZERO && hz.rd_w == hz.rs1_e) ? 2'b01 : 2'b00;
    hz.fwd_b_e = (hz.regwrite_m && hz.rd_m != ZERO && hz.rd_m == hz.rs2_e) ? 2'b10 :
                 (hz.regwrite_w && hz.rd_w != ZERO && hz.rd_w == hz.rs2_e) ? 2'b01 : 2'b00;
  end
`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset) begin
      hz.stall_cnt <= '0;
      hz.flush_cnt <= '0;
    end else begin
      if (!hz.en_d && !(&hz.stall_cnt)) hz.stall_cnt <= hz.stall_cnt + 1'b1;
      if (hz.clr_d && !(&hz.flush_cnt)) hz.flush_cnt <= hz.flush_cnt + 1'b1;
    end
`endif
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Pipeline control for the 5-stage RISC core (F/D/E/M/W). Generates the enable and clear inputs of every inter-stage enable/clear pipeline register, plus E-stage forwarding selects.
- Handles three hazard sources:
  - load-use stalls;
  - taken-branch/jump flushes;
  - multi-cycle data-memory waits, tracked by a timeout FSM.

Parameters:
- REG_AW, 5, register-address width.
- MAX_WAIT, 16, memory-wait cycles before timeout; legal range 2..255.
- CNT_W, 32, performance-counter width (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- rs1_d, rs2_d  in  REG_AW  D-stage source registers.
- rs1_e, rs2_e  in  REG_AW  E-stage source registers.
- rd_e, rd_m, rd_w  in  REG_AW  destination registers in E, M and W.
- load_e  in  1  E-stage instruction is a load.
- regwrite_m, regwrite_w  in  1  M/W instruction writes the register file.
- pc_src_e  in  1  taken branch or jump resolved in E.
- mem_req_m  in  1  M-stage data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- en_f, en_d, en_e, en_m, en_w  out  1  stage-register enables.
- clr_d, clr_e, clr_w  out  1  stage-register clears (bubble insert).
- fwd_a_e, fwd_b_e  out  2  forward select: 00 = regfile, 01 = W result, 10 = M ALU result.
- mem_timeout  out  1  sticky timeout flag.

Behaviour:
- A clear takes effect only while the matching enable is 1. Every asserted clr_x must therefore have en_x = 1 in the same cycle.
- Forwarding (combinational), shown for A; B is identical using rs2_e:
  - 10 if regwrite_m, rd_m != 0 and rd_m == rs1_e.
  - Otherwise 01 if regwrite_w, rd_w != 0 and rd_w == rs1_e.
  - Otherwise 00.
  - M has priority over W.
- Signals:
  - lu = load_e & rd_e != 0 & (rd_e == rs1_d | rd_e == rs2_d).
  - mstall = mem_req_m & ~mem_ready & ~mem_timeout.
- Priority, highest first:
  1. mstall: en_f = en_d = en_e = en_m = 0; en_w = 1, clr_w = 1 (bubble into W); clr_d = clr_e = 0. pc_src_e is ignored; the branch stays frozen in E and is flushed on the first non-stall cycle.
  2. pc_src_e: all en = 1; clr_d = 1, clr_e = 1. Overrides lu because the stalled D instruction is on the wrong path.
  3. lu: en_f = en_d = 0; clr_e = 1 with en_e = 1; others enabled.
  4. None: all en = 1, all clr = 0.
- FSM, state register updated on the clk edge:
  - IDLE: mem_req_m & ~mem_ready -> WAIT, cnt = 1.
  - WAIT, mem_ready: -> IDLE, cnt = 0.
  - WAIT, cnt == MAX_WAIT - 1 and ~mem_ready: -> TIMEOUT.
  - WAIT, otherwise: cnt = cnt + 1.
  - TIMEOUT: mem_timeout = 1 and the pipeline is released (mstall = 0). Exit only by reset.
- A ready arriving in the same cycle as the request causes no stall and no state change.
- Reset: state = IDLE, cnt = 0, mem_timeout = 0. All en/clr/fwd are combinational and have no reset value of their own; with zero inputs they are en = 1, clr = 0, fwd = 00.
- Reset asserted mid-WAIT forces IDLE on the next edge regardless of mem_ready.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined: adds outputs stall_cnt and flush_cnt, each CNT_W bits, reset to 0.
  - stall_cnt increments on every cycle where lu or mstall drives en_d = 0.
  - flush_cnt increments on every cycle where clr_d is asserted by pc_src_e.
  - Both saturate at all-ones; there is no wrap.
- Undefined: the ports and counters are absent, and the remaining logic is unchanged.

Test Plan:
- Load-use: load_e = 1, rd_e = 5, rs1_d = 5 -> en_f = en_d = 0, clr_e = 1, en_e = 1 for one cycle.
- Load-use with rd_e = 0 -> no stall.
- Forwarding: rd_m = rd_w = 7, regwrite_m = regwrite_w = 1, rs1_e = 7 -> fwd_a_e = 10. Drop regwrite_m -> fwd_a_e = 01. With rs1_e = 0 -> 00.
- Branch + load-use in the same cycle: pc_src_e = 1, lu = 1 -> all en = 1, clr_d = clr_e = 1.
- Memory wait: mem_req_m = 1, mem_ready low for 3 cycles, then high -> 3 cycles of en_f..en_m = 0 and clr_w = 1, FSM returns to IDLE. With pc_src_e = 1 held, clr_d/clr_e are asserted in the cycle ready arrives.
- Timeout: MAX_WAIT = 4, mem_ready never asserts -> mem_timeout = 1 after 4 stall cycles, en released, flag held until reset. Then assert reset -> flag = 0, state = IDLE.
